// File: rtl/pipe_register.sv
// pipe_register: enable-gated pipeline register chain with async active-low reset.
// Optional per-stage even parity and o_perr flag when REGISTER_PARITY_EN is defined.
module pipe_register #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               STAGES  = 1
) (
    output logic [WIDTH-1:0] o_q,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_rst_n,
    input  logic             i_clk
`ifdef REGISTER_PARITY_EN
    ,
    output logic             o_perr
`endif
);

    logic [WIDTH-1:0] s [STAGES];

    // Data chain: all stages advance together on an enabled edge; an X enable smears into the stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) s[k] <= RST_VAL;
        end else begin
            s[0] <= i_en ? i_d : s[0];
            for (int k = 1; k < STAGES; k++) s[k] <= i_en ? s[k-1] : s[k];
        end
    end

    assign o_q = s[STAGES-1];

`ifdef REGISTER_PARITY_EN
    logic p [STAGES];

    // Parity chain: even parity of the loaded word travels alongside its data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) p[k] <= ^RST_VAL;
        end else begin
            p[0] <= i_en ? ^i_d : p[0];
            for (int k = 1; k < STAGES; k++) p[k] <= i_en ? p[k-1] : p[k];
        end
    end

    assign o_perr = (^s[STAGES-1]) ^ p[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register: scoreboard bench for 32-bit, 3-stage 8-bit and 1-bit pipe_register instances.
module tb_pipe_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d32;
    logic        en32;
    logic [31:0] q32;
    logic [7:0]  d8;
    logic        en8;
    logic [7:0]  q8;
    logic        d1;
    logic        q1;
`ifdef REGISTER_PARITY_EN
    logic        perr32, perr8, perr1;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] sb32[$];
    logic [7:0]  sb8[$];
    logic        sb1[$];
    logic [31:0] last32;
    logic [7:0]  last8;
    logic        last1;

    always #5 clk = ~clk;

    pipe_register #(.WIDTH(32), .STAGES(1)) dut32 (
        .o_q(q32), .i_en(en32), .i_d(d32), .i_rst_n(rst_n), .i_clk(clk)
`ifdef REGISTER_PARITY_EN
        , .o_perr(perr32)
`endif
    );

    pipe_register #(.WIDTH(8), .RST_VAL(8'h5A), .STAGES(3)) dut8 (
        .o_q(q8), .i_en(en8), .i_d(d8), .i_rst_n(rst_n), .i_clk(clk)
`ifdef REGISTER_PARITY_EN
        , .o_perr(perr8)
`endif
    );

    pipe_register #(.WIDTH(1), .STAGES(1)) dut1 (
        .o_q(q1), .i_en(1'b1), .i_d(d1), .i_rst_n(rst_n), .i_clk(clk)
`ifdef REGISTER_PARITY_EN
        , .o_perr(perr1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all three instances for one edge, then compare each against its scoreboard.
    task automatic step(input logic [31:0] a, input logic ea, input logic [7:0] b, input logic eb, input logic c);
        d32 = a; en32 = ea; d8 = b; en8 = eb; d1 = c;
        if (ea) sb32.push_back(a);
        if (eb) sb8.push_back(b);
        sb1.push_back(c);
        tick();
        if (ea) last32 = sb32.pop_front();
        if (eb) last8 = sb8.pop_front();
        last1 = sb1.pop_front();
        check("q32", q32, last32);
        check("q8", {24'h0, q8}, {24'h0, last8});
        check("q1", {31'h0, q1}, {31'h0, last1});
`ifdef REGISTER_PARITY_EN
        check("perr", {29'h0, perr32, perr8, perr1}, 32'h0);
`endif
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; en32 = 1'b1; d32 = 32'hDEADBEEF; en8 = 1'b1; d8 = 8'h11; d1 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_q32", q32, 32'h0);
        check("rst_async_q8", {24'h0, q8}, 32'h5A);
        check("rst_async_q1", {31'h0, q1}, 32'h0);
        repeat (2) tick();
        check("rst_held_q32", q32, 32'h0);
        check("rst_held_q8", {24'h0, q8}, 32'h5A);
        @(negedge clk);
        rst_n = 1'b1; en8 = 1'b0;
        tick();
        check("post_rst_load_q32", q32, 32'hDEADBEEF);
        check("post_rst_hold_q8", {24'h0, q8}, 32'h5A);
        check("post_rst_load_q1", {31'h0, q1}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_q32", q32, 32'h0);
        check("midrun_rst_q1", {31'h0, q1}, 32'h0);
`ifdef REGISTER_PARITY_EN
        check("rst_perr", {31'h0, perr32}, 32'h0);
`endif
        tick();
        check("midrun_rst_held_q32", q32, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last32 = 32'h0; last8 = 8'h5A; last1 = 1'b0;
        sb8.push_back(8'h5A);
        sb8.push_back(8'h5A);
        step(32'h12345678, 1'b1, 8'hA1, 1'b1, 1'b1);
        step(32'hFFFFFFFF, 1'b0, 8'hA2, 1'b1, 1'b0);
        step(32'hFFFFFFFF, 1'b0, 8'hA3, 1'b1, 1'b1);
        step(32'hFFFFFFFF, 1'b0, 8'hFF, 1'b0, 1'b0);
        step(32'h00000001, 1'b1, 8'hEE, 1'b0, 1'b1);
        step(32'h80000000, 1'b1, 8'hA4, 1'b1, 1'b1);
        step(32'h0F0F0F0F, 1'b1, 8'hA5, 1'b1, 1'b0);
        step(32'hAAAAAAAA, 1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++)
            step($urandom, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
